// File: rtl/vreg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vreg_pkg
// Brief   : Shared widths and types for the vector register access controller.
// Revision: 1.0 - initial release
// ============================================================================
package vreg_pkg;

  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 64;
  localparam int NUM_VREGS = 8;

  typedef logic [ADDR_W-1:0] vaddr_t;
  typedef logic [DATA_W-1:0] vdata_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : One-hot grant among eligible requesters. VREG_RR_EN selects a
//           rotating pointer; otherwise fixed priority with index 0 highest.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 2
) (
`ifdef VREG_RR_EN
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
`endif
  input  logic [N-1:0] req,
  input  logic [N-1:0] elig,
  output logic [N-1:0] gnt
);

  logic [N-1:0] cand;

  assign cand = req & elig;

`ifdef VREG_RR_EN
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan from the pointer; the pointer lands just past the winner.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int j = 0; j < N; j++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(j);
      if (sum >= (PTR_W+1)'(N)) begin
        sum = sum - (PTR_W+1)'(N);
      end
      idx = sum[PTR_W-1:0];
      if (!found && cand[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = (int'(idx) == N-1) ? '0 : idx + 1'b1;
      end
    end
    if (flush) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && cand[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/vreg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : vreg_access_ctrl
// Brief   : Arbitrates the vector register bank write port and read pair,
//           with a pending-write scoreboard. Macro VREG_RR_EN enables
//           round-robin arbitration (fixed priority when undefined).
// Revision: 1.0 - initial release
// ============================================================================
module vreg_access_ctrl #(
  parameter int NW     = 2,
  parameter int NR     = 2,
  parameter int ADDR_W = vreg_pkg::ADDR_W,
  parameter int DATA_W = vreg_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic                 rsv_ready,
  input  logic [NW-1:0]        wr_req,
  input  logic [NW*ADDR_W-1:0] wr_addr,
  input  logic [NW*DATA_W-1:0] wr_data,
  output logic [NW-1:0]        wr_gnt,
  input  logic [NR-1:0]        rd_req,
  input  logic [NR*ADDR_W-1:0] rd_addr_a,
  input  logic [NR*ADDR_W-1:0] rd_addr_b,
  output logic [NR-1:0]        rd_gnt,
  output logic                 rd_valid,
  output logic [$clog2(NR)-1:0] rd_id,
  output logic [DATA_W-1:0]    rd_vA,
  output logic [DATA_W-1:0]    rd_vB,
  output logic [ADDR_W-1:0]    bank_dir_A,
  output logic [ADDR_W-1:0]    bank_dir_B,
  output logic [ADDR_W-1:0]    bank_dir_esc,
  output logic [DATA_W-1:0]    bank_data,
  output logic                 bank_signal_esc,
  output logic                 bank_signal_read,
  input  logic [DATA_W-1:0]    bank_vA,
  input  logic [DATA_W-1:0]    bank_vB
);

  import vreg_pkg::*;

  localparam int ID_W = $clog2(NR);

  logic [NUM_VREGS-1:0] busy_q, busy_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [ID_W-1:0]      rd_id_q, rd_id_d;
  logic                 active;
  logic [NW-1:0]        wr_elig;
  logic [NR-1:0]        rd_elig;
  logic                 wr_fire;
  logic [ADDR_W-1:0]    wr_addr_sel;
  logic [DATA_W-1:0]    wr_data_sel;
  logic [ADDR_W-1:0]    rd_a_sel, rd_b_sel;
  logic [ID_W-1:0]      rd_id_sel;

  // Grants are suppressed while in reset and during a flush cycle.
  assign active    = rst_n & ~flush;
  assign rsv_ready = ~busy_q[rsv_addr];
  assign wr_elig   = {NW{active}};

  rr_arbiter #(.N(NW)) u_wr_arb (
`ifdef VREG_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
`endif
    .req   (wr_req),
    .elig  (wr_elig),
    .gnt   (wr_gnt)
  );

  always_comb begin
    wr_addr_sel = '0;
    wr_data_sel = '0;
    for (int i = 0; i < NW; i++) begin
      if (wr_gnt[i]) begin
        wr_addr_sel = wr_addr[i*ADDR_W +: ADDR_W];
        wr_data_sel = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_fire = |wr_gnt;

  // A read touching this cycle's write target waits one cycle for the commit.
  generate
    for (genvar g = 0; g < NR; g++) begin : g_rd_elig
      logic [ADDR_W-1:0] a_addr, b_addr;
      assign a_addr     = rd_addr_a[g*ADDR_W +: ADDR_W];
      assign b_addr     = rd_addr_b[g*ADDR_W +: ADDR_W];
      assign rd_elig[g] = active & ~busy_q[a_addr] & ~busy_q[b_addr]
                        & ~(wr_fire & ((a_addr == wr_addr_sel) | (b_addr == wr_addr_sel)));
    end
  endgenerate

  rr_arbiter #(.N(NR)) u_rd_arb (
`ifdef VREG_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
`endif
    .req   (rd_req),
    .elig  (rd_elig),
    .gnt   (rd_gnt)
  );

  always_comb begin
    rd_a_sel  = '0;
    rd_b_sel  = '0;
    rd_id_sel = '0;
    for (int i = 0; i < NR; i++) begin
      if (rd_gnt[i]) begin
        rd_a_sel  = rd_addr_a[i*ADDR_W +: ADDR_W];
        rd_b_sel  = rd_addr_b[i*ADDR_W +: ADDR_W];
        rd_id_sel = ID_W'(i);
      end
    end
  end

  assign bank_dir_esc     = wr_addr_sel;
  assign bank_data        = wr_data_sel;
  assign bank_signal_esc  = wr_fire;
  assign bank_dir_A       = rd_a_sel;
  assign bank_dir_B       = rd_b_sel;
  assign bank_signal_read = |rd_gnt;

  // Reservation is applied after the write clear so a same-address set wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_fire) begin
      busy_d[wr_addr_sel] = 1'b0;
    end
    if (rsv_valid && rsv_ready) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    rd_valid_d = bank_signal_read;
    rd_id_d    = bank_signal_read ? rd_id_sel : rd_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
    end else begin
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_vA    = bank_vA;
  assign rd_vB    = bank_vB;

endmodule
`default_nettype wire

// File: tb/tb_vreg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_vreg_access_ctrl
// Brief   : Self-checking bench for vreg_access_ctrl against a cycle-level
//           reference model; follows VREG_RR_EN like the design.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vreg_access_ctrl;

  localparam int NW = 2;
  localparam int NR = 2;
  localparam int AW = 3;
  localparam int DW = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           rsv_valid = 1'b0;
  logic [AW-1:0]  rsv_addr = '0;
  logic           rsv_ready;
  logic [NW-1:0]  wr_req = '0;
  logic [NW*AW-1:0] wr_addr = '0;
  logic [NW*DW-1:0] wr_data = '0;
  logic [NW-1:0]  wr_gnt;
  logic [NR-1:0]  rd_req = '0;
  logic [NR*AW-1:0] rd_addr_a = '0;
  logic [NR*AW-1:0] rd_addr_b = '0;
  logic [NR-1:0]  rd_gnt;
  logic           rd_valid;
  logic [0:0]     rd_id;
  logic [DW-1:0]  rd_vA, rd_vB;
  logic [AW-1:0]  bank_dir_A, bank_dir_B, bank_dir_esc;
  logic [DW-1:0]  bank_data;
  logic           bank_signal_esc, bank_signal_read;
  logic [DW-1:0]  bank_vA, bank_vB;

  always #5 clk = ~clk;

  vreg_access_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .rsv_valid        (rsv_valid),
    .rsv_addr         (rsv_addr),
    .rsv_ready        (rsv_ready),
    .wr_req           (wr_req),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_gnt           (wr_gnt),
    .rd_req           (rd_req),
    .rd_addr_a        (rd_addr_a),
    .rd_addr_b        (rd_addr_b),
    .rd_gnt           (rd_gnt),
    .rd_valid         (rd_valid),
    .rd_id            (rd_id),
    .rd_vA            (rd_vA),
    .rd_vB            (rd_vB),
    .bank_dir_A       (bank_dir_A),
    .bank_dir_B       (bank_dir_B),
    .bank_dir_esc     (bank_dir_esc),
    .bank_data        (bank_data),
    .bank_signal_esc  (bank_signal_esc),
    .bank_signal_read (bank_signal_read),
    .bank_vA          (bank_vA),
    .bank_vB          (bank_vB)
  );

  // Register bank: write commits at the edge, read data registered at the edge.
  logic [DW-1:0] bank_mem [8];
  always @(posedge clk) begin
    if (bank_signal_esc) bank_mem[bank_dir_esc] <= bank_data;
    if (bank_signal_read) begin
      bank_vA <= bank_mem[bank_dir_A];
      bank_vB <= bank_mem[bank_dir_B];
    end
  end

  // Reference state
  bit            busy_m [8];
  logic [DW-1:0] mem_m  [8];
  int            wptr_m = 0;
  int            rptr_m = 0;
  bit            exp_rv = 1'b0;
  int            exp_rid = 0;
  logic [DW-1:0] exp_va = '0;
  logic [DW-1:0] exp_vb = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // First eligible client scanning upward from ptr (ptr stays 0 for fixed priority).
  function automatic int pick(input logic [1:0] el, input int ptr);
    int idx;
    pick = -1;
    for (int k = 0; k < 2; k++) begin
      idx = (ptr + k) % 2;
      if (pick < 0 && el[idx]) pick = idx;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) busy_m[i] = 1'b0;
    wptr_m = 0;
    rptr_m = 0;
    exp_rv = 1'b0;
    exp_rid = 0;
  endtask

  // Inputs are set at a negedge; checks the cycle and returns at the next negedge.
  task automatic cycle();
    int ws, rs;
    logic [AW-1:0] wa, ra, rb;
    logic [DW-1:0] wd;
    logic [NR-1:0] el;
    logic [NW-1:0] ew;
    logic [NR-1:0] er;
    bit acc;
    #1;
    ws = flush ? -1 : pick(wr_req, wptr_m);
    wa = '0; wd = '0; ew = '0;
    if (ws >= 0) begin
      wa = wr_addr[ws*AW +: AW];
      wd = wr_data[ws*DW +: DW];
      ew[ws] = 1'b1;
    end
    for (int i = 0; i < NR; i++) begin
      ra = rd_addr_a[i*AW +: AW];
      rb = rd_addr_b[i*AW +: AW];
      el[i] = rd_req[i] && !flush && !busy_m[ra] && !busy_m[rb]
              && !(ws >= 0 && (ra == wa || rb == wa));
    end
    rs = pick(el, rptr_m);
    er = '0; ra = '0; rb = '0;
    if (rs >= 0) begin
      er[rs] = 1'b1;
      ra = rd_addr_a[rs*AW +: AW];
      rb = rd_addr_b[rs*AW +: AW];
    end
    check("wr_gnt", wr_gnt, ew);
    check("rd_gnt", rd_gnt, er);
    check("rsv_ready", rsv_ready, !busy_m[rsv_addr]);
    check("sig_esc", bank_signal_esc, ws >= 0);
    check("sig_read", bank_signal_read, rs >= 0);
    if (ws >= 0) begin
      check("dir_esc", bank_dir_esc, wa);
      check("bank_data", bank_data, wd);
    end
    if (rs >= 0) begin
      check("dir_A", bank_dir_A, ra);
      check("dir_B", bank_dir_B, rb);
    end
    acc = rsv_valid && !busy_m[rsv_addr];
    @(posedge clk);
    exp_rv = (rs >= 0);
    if (rs >= 0) begin
      exp_rid = rs;
      exp_va  = mem_m[ra];
      exp_vb  = mem_m[rb];
    end
    if (ws >= 0) begin
      mem_m[wa]  = wd;
      busy_m[wa] = 1'b0;
    end
    if (acc) busy_m[rsv_addr] = 1'b1;
`ifdef VREG_RR_EN
    if (ws >= 0) wptr_m = (ws + 1) % NW;
    if (rs >= 0) rptr_m = (rs + 1) % NR;
`endif
    if (flush) model_reset();
    @(negedge clk);
    check("rd_valid", rd_valid, exp_rv);
    if (exp_rv) begin
      check("rd_id", rd_id, 64'(exp_rid));
      check("rd_vA", rd_vA, exp_va);
      check("rd_vB", rd_vB, exp_vb);
    end
  endtask

  task automatic idle();
    wr_req = '0; rd_req = '0; rsv_valid = 1'b0; flush = 1'b0;
  endtask

  logic [NW-1:0] exp_w;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    // Reset state
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_id", rd_id, 0);
    check("rst_wr_gnt", wr_gnt, 0);
    check("rst_rd_gnt", rd_gnt, 0);
    check("rst_esc", bank_signal_esc, 0);
    check("rst_read", bank_signal_read, 0);
    check("rst_dir_esc", bank_dir_esc, 0);
    check("rst_data", bank_data, 0);
    check("rst_dir_A", bank_dir_A, 0);
    check("rst_dir_B", bank_dir_B, 0);
    for (int a = 0; a < 8; a++) begin
      rsv_addr = AW'(a);
      #1 check("rst_rsv_ready", rsv_ready, 1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every register so reads return known data
    for (int a = 0; a < 8; a++) begin
      wr_req = 2'b01;
      wr_addr[0 +: AW] = AW'(a);
      wr_data[0 +: DW] = {$urandom, $urandom};
      cycle();
    end
    idle();

    // Single write then read
    wr_req = 2'b01; wr_addr[0 +: AW] = 3'd5; wr_data[0 +: DW] = 64'd6;
    cycle();
    idle();
    rd_req = 2'b10; rd_addr_a[AW +: AW] = 3'd5; rd_addr_b[AW +: AW] = 3'd5;
    cycle();
    check("sw_valid", rd_valid, 1);
    check("sw_id", rd_id, 1);
    check("sw_vA", rd_vA, 64'd6);
    check("sw_vB", rd_vB, 64'd6);
    idle();

    // Reset asserted while a read result is valid, with busy[7] set
    rd_req = 2'b01; rd_addr_a[0 +: AW] = 3'd0; rd_addr_b[0 +: AW] = 3'd1;
    rsv_valid = 1'b1; rsv_addr = 3'd7;
    cycle();
    rsv_valid = 1'b0;
    wr_req = 2'b01; wr_addr[0 +: AW] = 3'd2;
    rst_n = 1'b0;
    #1;
    check("mr_rd_valid", rd_valid, 0);
    check("mr_rd_gnt", rd_gnt, 0);
    check("mr_wr_gnt", wr_gnt, 0);
    for (int a = 0; a < 8; a++) begin
      rsv_addr = AW'(a);
      #1 check("mr_rsv_ready", rsv_ready, 1);
    end
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Write contention for four cycles
    wr_req = 2'b11; wr_addr = {3'd7, 3'd1};
    wr_data = {64'h77, 64'h11};
    for (int k = 0; k < 4; k++) begin
`ifdef VREG_RR_EN
      exp_w = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_w = 2'b01;
`endif
      #1 check("contention", wr_gnt, exp_w);
      cycle();
    end
    idle();

    // Scoreboard blocks a read until the reserved register is written
    rsv_valid = 1'b1; rsv_addr = 3'd3;
    cycle();
    rsv_valid = 1'b0;
    rd_req = 2'b01; rd_addr_a[0 +: AW] = 3'd3; rd_addr_b[0 +: AW] = 3'd0;
    repeat (2) begin
      #1 check("sb_blocked", rd_gnt, 0);
      cycle();
    end
    wr_req = 2'b10; wr_addr[AW +: AW] = 3'd3; wr_data[DW +: DW] = 64'hAB;
    #1 check("sb_write_cycle", rd_gnt, 0);
    cycle();
    wr_req = '0;
    #1 check("sb_granted", rd_gnt, 2'b01);
    cycle();
    check("sb_data", rd_vA, 64'hAB);
    idle();

    // Same-cycle write/read on one address: read deferred, sees new value
    wr_req = 2'b01; wr_addr[0 +: AW] = 3'd2; wr_data[0 +: DW] = 64'h22;
    rd_req = 2'b01; rd_addr_a[0 +: AW] = 3'd2; rd_addr_b[0 +: AW] = 3'd0;
    #1 check("haz_wr", wr_gnt, 2'b01);
    check("haz_rd", rd_gnt, 2'b00);
    cycle();
    wr_req = '0;
    #1 check("haz_rd_next", rd_gnt, 2'b01);
    cycle();
    check("haz_data", rd_vA, 64'h22);
    idle();

    // Reserve and write the same address in one cycle: set wins
    rsv_valid = 1'b1; rsv_addr = 3'd4;
    wr_req = 2'b01; wr_addr[0 +: AW] = 3'd4; wr_data[0 +: DW] = 64'h44;
    cycle();
    idle();
    #1 check("set_wins", rsv_ready, 0);

    // Flush clears busy bits and blocks grants in the flush cycle
    rsv_valid = 1'b1; rsv_addr = 3'd1;
    cycle();
    rsv_addr = 3'd6;
    cycle();
    rsv_valid = 1'b0;
    flush = 1'b1;
    wr_req = 2'b11; wr_addr = {3'd0, 3'd5};
    rd_req = 2'b11; rd_addr_a = {3'd5, 3'd0}; rd_addr_b = {3'd0, 3'd5};
    #1 check("fl_wr_gnt", wr_gnt, 0);
    check("fl_rd_gnt", rd_gnt, 0);
    cycle();
    idle();
    rsv_addr = 3'd1;
    #1 check("fl_ready1", rsv_ready, 1);
    rsv_addr = 3'd6;
    #1 check("fl_ready6", rsv_ready, 1);
    @(negedge clk);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      wr_req    = NW'($urandom);
      wr_addr   = (NW*AW)'($urandom);
      wr_data   = {$urandom, $urandom, $urandom, $urandom};
      rd_req    = NR'($urandom);
      rd_addr_a = (NR*AW)'($urandom);
      rd_addr_b = (NR*AW)'($urandom);
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = AW'($urandom);
      flush     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
